// File: rtl/synapse_pkg.sv
// Shared definitions for the synapse connectivity store: bus widths, default address map,
// control register layout and the clear-engine state encoding.
package synapse_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'h3000_F000;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_BUSY_BIT  = 0;
  localparam int CTRL_NAXON_LSB = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Status word returned when the control register is read.
  function automatic logic [WB_DATA_W-1:0] ctrlStatus(input logic [15:0] numAxons,
                                                      input logic        busy);
    logic [WB_DATA_W-1:0] status;
    status                         = '0;
    status[CTRL_NAXON_LSB +: 16]   = numAxons;
    status[CTRL_BUSY_BIT]          = busy;
    return status;
  endfunction

endpackage

// File: rtl/synapse_matrix_banked_ram.sv
// Row-organised connection array: byte-lane word writes, registered word and full-row reads,
// and a single-row clear port used by the clear engine. Array contents are never reset.
module synapse_row_ram
  import synapse_pkg::*;
#(
  parameter int NUM_AXONS   = 256,
  parameter int NUM_NEURONS = 32,
  localparam int WPR    = NUM_NEURONS / WB_DATA_W,
  localparam int ROW_W  = $clog2(NUM_AXONS),
  localparam int LANE_W = (WPR > 1) ? $clog2(WPR) : 1,
  localparam int BIT_W  = $clog2(NUM_NEURONS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [ROW_W-1:0]       wr_row_i,
  input  logic [LANE_W-1:0]      wr_lane_i,
  input  logic [WB_SEL_W-1:0]    wr_be_i,
  input  logic [WB_DATA_W-1:0]   wr_data_i,
  input  logic                   rd_en_i,
  input  logic [ROW_W-1:0]       rd_row_i,
  input  logic [LANE_W-1:0]      rd_lane_i,
  output logic [WB_DATA_W-1:0]   rd_data_o,
  input  logic                   row_rd_en_i,
  input  logic [ROW_W-1:0]       row_rd_idx_i,
  output logic [NUM_NEURONS-1:0] row_data_o,
  input  logic                   clr_en_i,
  input  logic [ROW_W-1:0]       clr_row_i
);

  logic [NUM_NEURONS-1:0] mem_q [NUM_AXONS];
  logic [WB_DATA_W-1:0]   rdData_q;
  logic [NUM_NEURONS-1:0] rowData_q;
  logic [WB_DATA_W-1:0]   byteMask;
  logic [BIT_W-1:0]       wrBase;
  logic [BIT_W-1:0]       rdBase;

  assign wrBase = BIT_W'(wr_lane_i) << $clog2(WB_DATA_W);
  assign rdBase = BIT_W'(rd_lane_i) << $clog2(WB_DATA_W);

  // Expand the byte enables into a bit mask for the read-modify-write merge.
  always_comb begin
    byteMask = '0;
    for (int b = 0; b < WB_SEL_W; b++) begin
      byteMask[b*8 +: 8] = {8{wr_be_i[b]}};
    end
  end

  // Array update: the clear engine owns the array while running, otherwise merge the WB write.
  always_ff @(posedge clk_i) begin
    if (clr_en_i) begin
      mem_q[clr_row_i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_row_i][wrBase +: WB_DATA_W] <=
        (mem_q[wr_row_i][wrBase +: WB_DATA_W] & ~byteMask) | (wr_data_i & byteMask);
    end
  end

  // Registered read ports; they see the array as it was before any same-edge write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdData_q  <= '0;
      rowData_q <= '0;
    end else begin
      if (rd_en_i) begin
        rdData_q <= mem_q[rd_row_i][rdBase +: WB_DATA_W];
      end
      if (row_rd_en_i) begin
        rowData_q <= mem_q[row_rd_idx_i];
      end
    end
  end

  assign rd_data_o  = rdData_q;
  assign row_data_o = rowData_q;

endmodule

// File: rtl/synapse_matrix_banked.sv
// Synapse connectivity store: Wishbone slave for the management SoC, valid/ready row port for
// the neuron core, and a hardware engine that clears the whole matrix one row per cycle.
module synapse_matrix_banked
  import synapse_pkg::*;
#(
  parameter int          NUM_AXONS   = 256,
  parameter int          NUM_NEURONS = 32,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [31:0] CTRL_ADDR   = DEF_CTRL_ADDR
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [WB_SEL_W-1:0]          wbs_sel_i,
  input  logic [31:0]                  wbs_adr_i,
  input  logic [WB_DATA_W-1:0]         wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [WB_DATA_W-1:0]         wbs_dat_o,
  input  logic                         axon_valid_i,
  input  logic [$clog2(NUM_AXONS)-1:0] axon_idx_i,
  output logic                         axon_ready_o,
  output logic [NUM_NEURONS-1:0]       neurons_connections_o,
  output logic                         conn_valid_o,
  output logic                         busy_o
);

  localparam int WPR       = NUM_NEURONS / WB_DATA_W;
  localparam int WPR_LOG   = $clog2(WPR);
  localparam int NUM_WORDS = NUM_AXONS * WPR;
  localparam int ROW_W     = $clog2(NUM_AXONS);
  localparam int LANE_W    = (WPR > 1) ? $clog2(WPR) : 1;

  state_e               state_q;
  logic [ROW_W-1:0]     clrCnt_q;
  logic                 busy_q;
  logic                 ack_q;
  logic                 srcRam_q;
  logic [WB_DATA_W-1:0] datHold_q;
  logic                 connValid_q;

  logic [31:0]          offset;
  logic [29:0]          wordIdx;
  logic [1:0]           unusedAdrBits;
  logic                 matHit;
  logic                 ctrlHit;
  logic [ROW_W-1:0]     rowIdx;
  logic [LANE_W-1:0]    laneIdx;
  logic                 wbReq;
  logic                 wbTake;
  logic                 matWr;
  logic                 matRd;
  logic                 ctrlWr;
  logic                 clrStart;
  logic                 coreAccept;
  logic [WB_DATA_W-1:0] ramRdData;

  assign offset        = wbs_adr_i - BASE_ADDR;
  assign wordIdx       = offset[31:2];
  assign unusedAdrBits = offset[1:0];
  assign matHit        = wordIdx < 30'(NUM_WORDS);
  assign ctrlHit       = (wbs_adr_i == CTRL_ADDR) && !matHit;
  assign rowIdx        = ROW_W'(wordIdx >> WPR_LOG);
  assign laneIdx       = LANE_W'(wordIdx & 30'(WPR - 1));

  assign wbReq      = wbs_cyc_i && wbs_stb_i && !ack_q;
  assign wbTake     = wbReq && !(matHit && (state_q == ST_CLEAR));
  assign matWr      = wbTake && wbs_we_i && matHit;
  assign matRd      = wbTake && !wbs_we_i && matHit;
  assign ctrlWr     = wbTake && wbs_we_i && ctrlHit;
  assign clrStart   = ctrlWr && wbs_dat_i[CTRL_START_BIT] && (state_q == ST_IDLE);
  assign coreAccept = axon_valid_i && axon_ready_o;

  synapse_row_ram #(
    .NUM_AXONS   (NUM_AXONS),
    .NUM_NEURONS (NUM_NEURONS)
  ) u_ram (
    .clk_i        (wb_clk_i),
    .rst_ni       (wb_rst_i),
    .wr_en_i      (matWr),
    .wr_row_i     (rowIdx),
    .wr_lane_i    (laneIdx),
    .wr_be_i      (wbs_sel_i),
    .wr_data_i    (wbs_dat_i),
    .rd_en_i      (matRd),
    .rd_row_i     (rowIdx),
    .rd_lane_i    (laneIdx),
    .rd_data_o    (ramRdData),
    .row_rd_en_i  (coreAccept),
    .row_rd_idx_i (axon_idx_i),
    .row_data_o   (neurons_connections_o),
    .clr_en_i     (state_q == ST_CLEAR),
    .clr_row_i    (clrCnt_q)
  );

  // Wishbone response: single-cycle ack, read data taken from the RAM or from the held register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_q     <= 1'b0;
      srcRam_q  <= 1'b0;
      datHold_q <= '0;
    end else begin
      ack_q <= wbTake;
      if (wbTake && !wbs_we_i) begin
        srcRam_q <= matHit;
        if (!matHit) begin
          datHold_q <= ctrlHit ? ctrlStatus(16'(NUM_AXONS), busy_q) : '0;
        end
      end
    end
  end

  // Clear engine: walks every row once, then hands the array back to normal traffic.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q  <= ST_IDLE;
      clrCnt_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clrStart) begin
            state_q  <= ST_CLEAR;
            clrCnt_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clrCnt_q == ROW_W'(NUM_AXONS - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clrCnt_q <= clrCnt_q + ROW_W'(1);
          end
        end
      endcase
    end
  end

  // Core handshake: one-cycle valid pulse alongside the row fetched on acceptance.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      connValid_q <= 1'b0;
    end else begin
      connValid_q <= coreAccept;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = srcRam_q ? ramRdData : datHold_q;
  assign axon_ready_o = (state_q == ST_IDLE);
  assign conn_valid_o = connValid_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_synapse_matrix_banked.sv
// Scoreboard bench for synapse_matrix_banked with a two-word-per-row configuration.
module tb_synapse_matrix_banked;

  localparam int NA    = 256;
  localparam int NN    = 64;
  localparam int WPR   = NN / 32;
  localparam int NW    = NA * WPR;
  localparam int IDX_W = $clog2(NA);
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] CTRL = 32'h3000_F000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wbs_cyc_i = 1'b0;
  logic             wbs_stb_i = 1'b0;
  logic             wbs_we_i = 1'b0;
  logic [3:0]       wbs_sel_i = 4'h0;
  logic [31:0]      wbs_adr_i = 32'h0;
  logic [31:0]      wbs_dat_i = 32'h0;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic             axon_valid_i = 1'b0;
  logic [IDX_W-1:0] axon_idx_i = '0;
  logic             axon_ready_o;
  logic [NN-1:0]    neurons_connections_o;
  logic             conn_valid_o;
  logic             busy_o;

  always #5 clk = ~clk;

  synapse_matrix_banked #(
    .NUM_AXONS   (NA),
    .NUM_NEURONS (NN),
    .BASE_ADDR   (BASE),
    .CTRL_ADDR   (CTRL)
  ) dut (
    .wb_clk_i              (clk),
    .wb_rst_i              (rst_n),
    .wbs_cyc_i             (wbs_cyc_i),
    .wbs_stb_i             (wbs_stb_i),
    .wbs_we_i              (wbs_we_i),
    .wbs_sel_i             (wbs_sel_i),
    .wbs_adr_i             (wbs_adr_i),
    .wbs_dat_i             (wbs_dat_i),
    .wbs_ack_o             (wbs_ack_o),
    .wbs_dat_o             (wbs_dat_o),
    .axon_valid_i          (axon_valid_i),
    .axon_idx_i            (axon_idx_i),
    .axon_ready_o          (axon_ready_o),
    .neurons_connections_o (neurons_connections_o),
    .conn_valid_o          (conn_valid_o),
    .busy_o                (busy_o)
  );

  typedef struct {
    bit          isRead;
    logic [31:0] data;
  } wbExp_t;

  wbExp_t        wbQ[$];
  logic [NN-1:0] connQ[$];
  int            checks = 0;
  int            errors = 0;
  bit   [31:0]   mem[NW];
  logic          ackPrev = 1'b0;

  // One comparison: counts it and reports a mismatch.
  function automatic void checkOutput(input string name, input logic [63:0] act,
                                      input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void failNow(input string name, input string msg);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, msg);
  endfunction

  // Reference model: flat word array, matrix window is NW words starting at BASE.
  function automatic bit inWindow(input logic [31:0] adr);
    logic [31:0] off;
    off = adr - BASE;
    return (off / 4) < NW;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] adr);
    if (inWindow(adr)) return mem[(adr - BASE) / 4];
    return 32'h0;
  endfunction

  function automatic void modelWrite(input logic [31:0] adr, input logic [31:0] dat,
                                     input logic [3:0] sel);
    int w;
    if (!inWindow(adr)) return;
    w = (adr - BASE) / 4;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) mem[w][b*8 +: 8] = dat[b*8 +: 8];
    end
  endfunction

  function automatic logic [NN-1:0] modelRow(input int idx);
    logic [NN-1:0] r;
    for (int k = 0; k < WPR; k++) r[32*k +: 32] = mem[idx*WPR + k];
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an ack or a row.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wbs_ack_o) begin
        checkOutput("ack_one_cycle", {63'b0, ackPrev}, 64'd0);
        if (wbQ.size() == 0) begin
          failNow("wb_unexpected_ack", "got ack with empty queue, expected none");
        end else begin
          wbExp_t e;
          e = wbQ.pop_front();
          if (e.isRead) checkOutput("wb_read_data", {32'b0, wbs_dat_o}, {32'b0, e.data});
        end
      end
      if (conn_valid_o) begin
        if (connQ.size() == 0) begin
          failNow("conn_unexpected", "got conn_valid with empty queue, expected none");
        end else begin
          logic [NN-1:0] c;
          c = connQ.pop_front();
          checkOutput("core_row_data", neurons_connections_o, c);
        end
      end
      ackPrev = wbs_ack_o;
    end else begin
      ackPrev = 1'b0;
    end
  end

  task automatic wbXfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] expData, input bit expStall);
    int     waitCyc;
    wbExp_t ent;
    waitCyc    = 0;
    ent.isRead = !we;
    ent.data   = expData;
    @(posedge clk); #1;
    wbQ.push_back(ent);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    do begin
      @(posedge clk); #1;
      waitCyc++;
    end while (!wbs_ack_o && waitCyc < 2000);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (!wbs_ack_o) failNow("wb_ack_timeout", "got no ack in 2000 cycles, expected ack");
    else if (expStall) checkOutput("wb_ack_stalled", {63'b0, waitCyc > 1}, 64'd1);
    else checkOutput("wb_ack_latency", 64'(waitCyc), 64'd1);
  endtask

  task automatic wbWrite(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wbXfer(1'b1, adr, dat, sel, 32'h0, 1'b0);
    modelWrite(adr, dat, sel);
  endtask

  task automatic wbReadExp(input logic [31:0] adr, input logic [31:0] exp, input bit expStall);
    wbXfer(1'b0, adr, 32'h0, 4'hF, exp, expStall);
  endtask

  task automatic wbRead(input logic [31:0] adr);
    wbReadExp(adr, modelRead(adr), 1'b0);
  endtask

  task automatic coreReadExp(input int idx, input logic [NN-1:0] exp);
    int w;
    w = 0;
    @(posedge clk); #1;
    connQ.push_back(exp);
    axon_valid_i = 1'b1;
    axon_idx_i   = IDX_W'(idx);
    while (!axon_ready_o && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!axon_ready_o) failNow("core_ready_timeout", "got ready=0 for 2000 cycles, expected 1");
    @(posedge clk); #1;
    axon_valid_i = 1'b0;
  endtask

  task automatic coreRead(input int idx);
    coreReadExp(idx, modelRow(idx));
  endtask

  // Randomised mix of matrix writes, reads, core fetches and out-of-window traffic.
  task automatic applyStimulus(input int nOps);
    int r;
    int w;
    for (int i = 0; i < nOps; i++) begin
      r = $urandom_range(0, 9);
      w = $urandom_range(0, NW - 1);
      if (r <= 3) wbWrite(BASE + 32'(4 * w), $urandom, 4'($urandom_range(0, 15)));
      else if (r <= 6) wbRead(BASE + 32'(4 * w));
      else if (r <= 8) coreRead($urandom_range(0, NA - 1));
      else if ($urandom_range(0, 1) == 0) wbWrite(BASE + 32'(4 * (NW + w)), $urandom, 4'hF);
      else wbRead(BASE + 32'(4 * (NW + w)));
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0]   a;
    logic [31:0]   b;
    logic [NN-1:0] oldRow;
    int            busyCnt;

    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_ack", {63'b0, wbs_ack_o}, 64'd0);
    checkOutput("reset_dat", {32'b0, wbs_dat_o}, 64'd0);
    checkOutput("reset_conn_valid", {63'b0, conn_valid_o}, 64'd0);
    checkOutput("reset_busy", {63'b0, busy_o}, 64'd0);
    checkOutput("reset_connections", neurons_connections_o, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", {63'b0, axon_ready_o}, 64'd1);

    for (int w = 0; w < NW; w++) wbWrite(BASE + 32'(4 * w), $urandom, 4'hF);
    for (int w = 0; w < NW; w++) wbRead(BASE + 32'(4 * w));

    wbWrite(BASE + 32'h100, 32'hFFFF_FFFF, 4'hF);
    wbWrite(BASE + 32'h100, 32'h0, 4'b0010);
    wbReadExp(BASE + 32'h100, 32'hFFFF_00FF, 1'b0);

    a = $urandom;
    b = $urandom;
    wbWrite(BASE + 32'h10, a, 4'hF);
    wbWrite(BASE + 32'h14, b, 4'hF);
    coreReadExp(2, {b, a});

    applyStimulus(150);

    wbWrite(BASE + 32'(4 * (NW - 1)), 32'hA5A5_5A5A, 4'hF);
    wbRead(BASE + 32'(4 * (NW - 1)));
    wbWrite(BASE + 32'(4 * NW), 32'hDEAD_BEEF, 4'hF);
    wbReadExp(BASE + 32'(4 * NW), 32'h0, 1'b0);
    wbReadExp(BASE - 32'd4, 32'h0, 1'b0);
    wbReadExp(CTRL, 32'h0100_0000, 1'b0);
    coreRead(NA - 1);

    oldRow = modelRow(7);
    fork
      coreReadExp(7, oldRow);
      wbWrite(BASE + 32'h38, 32'h1234_5678, 4'hF);
    join
    wbReadExp(BASE + 32'h38, 32'h1234_5678, 1'b0);
    coreRead(7);

    wbWrite(CTRL, 32'h1, 4'hF);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("busy_before_abort", {63'b0, busy_o}, 64'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_busy", {63'b0, busy_o}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ready", {63'b0, axon_ready_o}, 64'd1);
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    coreRead(0);
    coreRead(NA - 1);
    wbRead(BASE + 32'(4 * (NW - 2)));

    wbWrite(CTRL, 32'h1, 4'hF);
    for (int i = 0; i < NW; i++) mem[i] = 32'h0;
    fork
      begin
        checkOutput("ready_low_in_clear", {63'b0, axon_ready_o}, 64'd0);
        busyCnt = 0;
        while (busy_o && busyCnt < 2000) begin
          @(posedge clk); #1;
          busyCnt++;
        end
        checkOutput("busy_cycles", 64'(busyCnt), 64'(NA));
      end
      begin
        wbReadExp(CTRL, 32'h0100_0001, 1'b0);
        wbXfer(1'b1, CTRL, 32'h1, 4'hF, 32'h0, 1'b0);
        wbReadExp(BASE + 32'h40, 32'h0, 1'b1);
      end
    join
    wbReadExp(CTRL, 32'h0100_0000, 1'b0);
    coreRead(100);
    wbRead(BASE + 32'(4 * 300));

    repeat (3) @(posedge clk);
    if (wbQ.size() != 0 || connQ.size() != 0)
      failNow("scoreboard_drain", "got pending expectations, expected empty queues");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
